mmio_io_responder: RTL and testbench
====================================

# mmio_io_responder

Memory-mapped I/O responder on the processor data bus. It serves the input side of the I/O page: synchronized, debounced KEY and SW state; sticky key-press event flags; and a programmable millisecond countdown timer with an interrupt output. The top level muxes DOUT into the data-memory read path whenever HIT is asserted, alongside the existing HEX/LED write registers.

## Interface
- DBITS, 16: bus data and address width
- DEB_TICK, 250000: cycles between debounce samples (5 ms at 50 MHz)
- TMR_TICK, 50000: cycles per timer decrement (1 ms at 50 MHz)
- KBITS, 4: number of keys
- SBITS, 10: number of switches

- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ADDR  in  DBITS  data bus address
- WE  in  1  write strobe, sampled at posedge CLK
- DIN  in  DBITS  write data
- DOUT  out  DBITS  read data, combinational from ADDR and internal registers
- HIT  out  1  ADDR decodes to one of this block's four registers
- KEY_IN  in  KBITS  raw key pads, active-low (0 = pressed)
- SW_IN  in  SBITS  raw switch pads, 1 = up
- IRQ  out  1  registered interrupt request

## Operation
- Register map:
  - 0xFFF0 KDATA (RO): debounced keys, 1 = pressed, zero-extended.
  - 0xFFF2 SDATA (RO): debounced switches, zero-extended.
  - 0xFFF4 KCTRL:
    - [3:0] key-press flags, R/W1C.
    - [4] timer-expired flag, R/W1C.
    - [11:8] key interrupt enables, R/W.
    - [12] timer interrupt enable, R/W.
    - Other bits read 0.
  - 0xFFF6 TIMER (R/W): current count; a write loads it.
- HIT = 1 only for those four addresses. DOUT = 0 when HIT = 0. Writes to RO registers are ignored.
- Input path:
  - Two-flop synchronizer on KEY_IN and SW_IN. Keys are inverted after synchronization.
  - A shared prescaler pulses SAMPLE every DEB_TICK cycles.
  - Each bit keeps its last sample. On SAMPLE, a bit's debounced value takes the new sample only if the new sample equals the previous sample.
- Press flags:
  - Flag i sets on the cycle that debounced key i goes 0→1.
  - A W1C write clears flags where DIN = 1.
  - Set and clear in the same cycle: set wins.
- Timer:
  - Writing TIMER loads DIN and restarts the tick prescaler at 0.
  - While count ≠ 0, count decrements on each TMR_TICK pulse.
  - The 1→0 decrement sets KCTRL[4].
  - A load of 0 stops the timer without setting the flag.
  - Load and tick in the same cycle: the load wins and no decrement occurs.
  - The count never wraps below 0.
- IRQ: registered; next value = |(KCTRL[4:0] & {KCTRL[12], KCTRL[11:8]}).
- Reset (async, RESET_N = 0), all cleared to 0:
  - synchronizers, samples, debounced state
  - flags, enables
  - TIMER, both prescalers
  - IRQ
- Reset mid-operation abandons the timer countdown and any debounce in progress. After release, KDATA reads 0; SDATA reads 0 until switch levels are stable for two samples.

## Timing
- Reads: zero wait states. DOUT is valid in the same cycle as ADDR, from register state as of the last edge.
- Writes take effect at the posedge where WE = 1. The new value is readable the following cycle.
- Pad change to KDATA/SDATA: 2 synchronizer cycles plus 1–2 SAMPLE periods, i.e. between DEB_TICK+2 and 2·DEB_TICK+2 cycles.
- Debounced key rise → flag visible the next cycle → IRQ one cycle after that (if enabled).
- Timer load N → flag set N·TMR_TICK cycles after the load edge.
- Flag clear → IRQ deasserts one cycle later.

## Structure
- The shared I/O package holds:
  - address constants ADDR_KDATA/ADDR_SDATA/ADDR_KCTRL/ADDR_TIMER (0xFFF0–0xFFF6)
  - KCTRL bit-position constants
  - existing HEX/LEDR/LEDG addresses (0xFFF8/A/C), so the top-level decoder and this block share one map.
- One sub-module, io_debounce: parameterized by width. It contains the synchronizer, sample register and agree-update logic, and takes SAMPLE as an input. It is instantiated once for keys and once for switches; the prescaler is shared.
- Timer, flags and bus decode live in the top module.

## Test plan
All scenarios use DEB_TICK=4, TMR_TICK=3.

- Reset: RESET_N low mid-count with TIMER=5 → all reads 0x0000, IRQ=0, TIMER stays 0 after release.
- Debounce and press flag:
  - KEY_IN[1] toggles for 3 cycles then settles low → KDATA=0x0002 within 10 cycles.
  - KCTRL reads 0x0002.
  - A glitch shorter than 4 cycles never changes KDATA.
- W1C and IRQ:
  - Write KCTRL=0x0200 → IRQ=1 two cycles after the bit-1 flag.
  - Write KCTRL=0x0202 → flag cleared, IRQ=0 next cycle, enable retained (reads 0x0200).
  - A press on the same cycle as the clear write leaves the flag set.
- Timer:
  - Write TIMER=2 → reads 1 after 3 cycles, 0 after 6 cycles, KCTRL[4]=1.
  - Write TIMER=0 → no flag.
  - A rewrite coinciding with a tick loads without decrement.
- Decode: reads of 0xFFF8 and 0x0100 → HIT=0, DOUT=0. A write of 0xFFFF to KDATA → KDATA is unchanged.
- Switches: SW_IN=0x2A5 held → SDATA=0x02A5 within 10 cycles; HIT=1 on 0xFFF2.

Source files
------------

// File: rtl/mmio_io_responder_pkg.sv
// Shared I/O page map for the data bus: input-side responder registers, the existing
// HEX/LED write registers, KCTRL bit positions and a register-select decoder.
package mmio_io_responder_pkg;

    localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
    localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
    localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
    localparam logic [15:0] ADDR_TIMER = 16'hFFF6;
    localparam logic [15:0] ADDR_HEX   = 16'hFFF8;
    localparam logic [15:0] ADDR_LEDR  = 16'hFFFA;
    localparam logic [15:0] ADDR_LEDG  = 16'hFFFC;

    localparam int unsigned KCTRL_KFLAG_LSB = 0;
    localparam int unsigned KCTRL_TFLAG     = 4;
    localparam int unsigned KCTRL_KEN_LSB   = 8;
    localparam int unsigned KCTRL_TEN       = 12;

    typedef enum logic [2:0] {
        RegNone,
        RegKdata,
        RegSdata,
        RegKctrl,
        RegTimer
    } io_reg_e;

    function automatic io_reg_e io_decode(input logic [15:0] addr);
        io_reg_e sel;
        case (addr)
            ADDR_KDATA: sel = RegKdata;
            ADDR_SDATA: sel = RegSdata;
            ADDR_KCTRL: sel = RegKctrl;
            ADDR_TIMER: sel = RegTimer;
            default:    sel = RegNone;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus sample-agreement debouncer; a bit's debounced value only
// follows the pad once two consecutive SAMPLE strobes see the same level.
module io_debounce #(
    parameter int unsigned WIDTH  = 1,
    parameter bit          INVERT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pad_i,
    input  logic             sample_i,
    output logic [WIDTH-1:0] deb_o
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] agree;

    always_comb begin
        sync1_d = pad_i;
        sync2_d = sync1_q;
        cur     = INVERT ? ~sync2_q : sync2_q;
        agree   = ~(cur ^ samp_q);
        samp_d  = samp_q;
        deb_d   = deb_q;
        if (sample_i) begin
            samp_d = cur;
            deb_d  = (agree & cur) | (~agree & deb_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/mmio_io_responder.sv
// Input side of the I/O page: debounced keys/switches, sticky press flags and a
// millisecond countdown timer, with a combinational read mux and a registered IRQ.
module mmio_io_responder
    import mmio_io_responder_pkg::*;
#(
    parameter int unsigned DBITS    = 16,
    parameter int unsigned DEB_TICK = 250000,
    parameter int unsigned TMR_TICK = 50000,
    parameter int unsigned KBITS    = 4,
    parameter int unsigned SBITS    = 10
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic             WE,
    input  logic [DBITS-1:0] DIN,
    output logic [DBITS-1:0] DOUT,
    output logic             HIT,
    input  logic [KBITS-1:0] KEY_IN,
    input  logic [SBITS-1:0] SW_IN,
    output logic             IRQ
);

    localparam int unsigned DebW = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
    localparam int unsigned TmrW = (TMR_TICK > 1) ? $clog2(TMR_TICK) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_TICK - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TMR_TICK - 1);

    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [TmrW-1:0]  tmr_cnt_q, tmr_cnt_d;
    logic [DBITS-1:0] count_q, count_d;
    logic [KBITS-1:0] kflag_q, kflag_d;
    logic [KBITS-1:0] ken_q, ken_d;
    logic [KBITS-1:0] kprev_q, kprev_d;
    logic             tflag_q, tflag_d;
    logic             ten_q, ten_d;
    logic             irq_q, irq_d;

    logic             sample;
    logic             tmr_tick;
    logic             expire;
    logic [KBITS-1:0] kdeb;
    logic [SBITS-1:0] sdeb;
    logic [15:0]      kctrl_rd;
    io_reg_e          reg_sel;
    logic             we_kctrl;
    logic             we_timer;

    assign sample = (deb_cnt_q == DebLast);

    // Keys are active-low at the pad; inverted after synchronization so 1 = pressed.
    io_debounce #(
        .WIDTH (KBITS),
        .INVERT(1'b1)
    ) u_key_deb (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .pad_i   (KEY_IN),
        .sample_i(sample),
        .deb_o   (kdeb)
    );

    io_debounce #(
        .WIDTH (SBITS),
        .INVERT(1'b0)
    ) u_sw_deb (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .pad_i   (SW_IN),
        .sample_i(sample),
        .deb_o   (sdeb)
    );

    assign reg_sel  = io_decode(ADDR[15:0]);
    assign we_kctrl = WE && (reg_sel == RegKctrl);
    assign we_timer = WE && (reg_sel == RegTimer);
    assign tmr_tick = (tmr_cnt_q == TmrLast);

    always_comb begin
        deb_cnt_d = sample ? '0 : deb_cnt_q + DebW'(1);
        tmr_cnt_d = (we_timer || tmr_tick) ? '0 : tmr_cnt_q + TmrW'(1);

        count_d = count_q;
        expire  = 1'b0;
        if (we_timer) begin
            count_d = DIN;
        end else if (tmr_tick && (count_q != '0)) begin
            count_d = count_q - DBITS'(1);
            expire  = (count_q == DBITS'(1));
        end

        // Clear first, then set, so a press coinciding with a W1C write survives.
        kflag_d = kflag_q;
        tflag_d = tflag_q;
        ken_d   = ken_q;
        ten_d   = ten_q;
        if (we_kctrl) begin
            kflag_d = kflag_q & ~DIN[KCTRL_KFLAG_LSB +: KBITS];
            tflag_d = tflag_q & ~DIN[KCTRL_TFLAG];
            ken_d   = DIN[KCTRL_KEN_LSB +: KBITS];
            ten_d   = DIN[KCTRL_TEN];
        end
        kflag_d = kflag_d | (kdeb & ~kprev_q);
        tflag_d = tflag_d | expire;
        kprev_d = kdeb;

        irq_d = |({tflag_q, kflag_q} & {ten_q, ken_q});
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_cnt_q <= '0;
            tmr_cnt_q <= '0;
            count_q   <= '0;
            kflag_q   <= '0;
            ken_q     <= '0;
            kprev_q   <= '0;
            tflag_q   <= 1'b0;
            ten_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            tmr_cnt_q <= tmr_cnt_d;
            count_q   <= count_d;
            kflag_q   <= kflag_d;
            ken_q     <= ken_d;
            kprev_q   <= kprev_d;
            tflag_q   <= tflag_d;
            ten_q     <= ten_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        kctrl_rd                                = '0;
        kctrl_rd[KCTRL_KFLAG_LSB +: KBITS]      = kflag_q;
        kctrl_rd[KCTRL_TFLAG]                   = tflag_q;
        kctrl_rd[KCTRL_KEN_LSB +: KBITS]        = ken_q;
        kctrl_rd[KCTRL_TEN]                     = ten_q;
    end

    always_comb begin
        DOUT = '0;
        case (reg_sel)
            RegKdata: DOUT = DBITS'(kdeb);
            RegSdata: DOUT = DBITS'(sdeb);
            RegKctrl: DOUT = DBITS'(kctrl_rd);
            RegTimer: DOUT = count_q;
            default:  DOUT = '0;
        endcase
    end

    assign HIT = (reg_sel != RegNone);
    assign IRQ = irq_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed plus randomized bench for mmio_io_responder with short debounce/timer ticks,
// checked against a level-based model of keys, switches, flags, enables and timer.
module tb_mmio_io_responder;

    localparam logic [15:0] KDATA = 16'hFFF0;
    localparam logic [15:0] SDATA = 16'hFFF2;
    localparam logic [15:0] KCTRL = 16'hFFF4;
    localparam logic [15:0] TIMER = 16'hFFF6;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] ADDR;
    logic        WE;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        HIT;
    logic [3:0]  KEY_IN;
    logic [9:0]  SW_IN;
    logic        IRQ;

    int vectors     = 0;
    int miscompares = 0;

    // Model: steady pad levels, sticky flags, enables.
    logic [3:0] m_kdeb;
    logic [3:0] m_kflag;
    logic [3:0] m_ken;
    logic       m_tflag;
    logic       m_ten;

    mmio_io_responder #(
        .DBITS   (16),
        .DEB_TICK(4),
        .TMR_TICK(3),
        .KBITS   (4),
        .SBITS   (10)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .ADDR   (ADDR),
        .WE     (WE),
        .DIN    (DIN),
        .DOUT   (DOUT),
        .HIT    (HIT),
        .KEY_IN (KEY_IN),
        .SW_IN  (SW_IN),
        .IRQ    (IRQ)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] m_kctrl();
        return {3'b000, m_ten, m_ken, 3'b000, m_tflag, m_kflag};
    endfunction

    function automatic logic m_irq();
        return (|(m_kflag & m_ken)) | (m_tflag & m_ten);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DIN  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        ADDR = a;
        #1;
        chk(tag, DOUT, exp);
    endtask

    initial begin
        logic [15:0] d;
        int n;

        RESET_N = 1'b1;
        WE      = 1'b0;
        ADDR    = 16'h0000;
        DIN     = 16'h0000;
        KEY_IN  = 4'hF;
        SW_IN   = 10'h000;
        #2 RESET_N = 1'b0;
        tick(3);
        RESET_N = 1'b1;
        tick(2);

        // Reset mid-count clears timer, enables and IRQ.
        wr(KCTRL, 16'h1F00);
        wr(TIMER, 16'd5);
        tick(4);
        chk_rd("timer_before_reset", TIMER, 16'd4);
        RESET_N = 1'b0;
        #1;
        chk_rd("rst_kdata", KDATA, 16'h0000);
        chk_rd("rst_sdata", SDATA, 16'h0000);
        chk_rd("rst_kctrl", KCTRL, 16'h0000);
        chk_rd("rst_timer", TIMER, 16'h0000);
        chk("rst_irq", {15'b0, IRQ}, 16'h0000);
        tick(2);
        RESET_N = 1'b1;
        tick(8);
        chk_rd("post_rst_timer", TIMER, 16'h0000);
        chk_rd("post_rst_kctrl", KCTRL, 16'h0000);

        // Decode and read-only behaviour.
        chk_rd("dout_fff8", 16'hFFF8, 16'h0000);
        chk("hit_fff8", {15'b0, HIT}, 16'h0000);
        chk_rd("dout_0100", 16'h0100, 16'h0000);
        chk("hit_0100", {15'b0, HIT}, 16'h0000);
        wr(KDATA, 16'hFFFF);
        chk_rd("kdata_ro", KDATA, 16'h0000);

        // Switches.
        SW_IN = 10'h2A5;
        tick(10);
        chk_rd("sdata_2a5", SDATA, 16'h02A5);
        chk("hit_sdata", {15'b0, HIT}, 16'h0001);

        // Bouncing key 1 settles pressed.
        for (int i = 0; i < 3; i++) begin
            KEY_IN[1] = ~KEY_IN[1];
            tick();
        end
        KEY_IN[1] = 1'b0;
        tick(10);
        chk_rd("kdata_key1", KDATA, 16'h0002);
        tick();
        chk_rd("kctrl_flag1", KCTRL, 16'h0002);

        // Short glitch on key 2 never reaches KDATA.
        KEY_IN[2] = 1'b0;
        tick(3);
        KEY_IN[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_rd("glitch_kdata", KDATA, 16'h0002);
        end
        chk_rd("glitch_kctrl", KCTRL, 16'h0002);

        // Enable key-1 interrupt, then W1C the flag.
        wr(KCTRL, 16'h0200);
        chk("irq_lat0", {15'b0, IRQ}, 16'h0000);
        chk_rd("kctrl_en", KCTRL, 16'h0202);
        tick();
        chk("irq_set", {15'b0, IRQ}, 16'h0001);
        wr(KCTRL, 16'h0202);
        chk_rd("kctrl_w1c", KCTRL, 16'h0200);
        chk("irq_hold", {15'b0, IRQ}, 16'h0001);
        tick();
        chk("irq_clr", {15'b0, IRQ}, 16'h0000);

        // Press lands on the same edge as a W1C: set wins.
        KEY_IN[1] = 1'b1;
        tick(12);
        chk_rd("kdata_release", KDATA, 16'h0000);
        KEY_IN[1] = 1'b0;
        for (int i = 0; i < 12 && DOUT[1] !== 1'b1; i++) tick();
        wr(KCTRL, 16'h0202);
        chk_rd("set_wins", KCTRL, 16'h0202);
        tick();
        chk("irq_set_wins", {15'b0, IRQ}, 16'h0001);
        wr(KCTRL, 16'h0002);
        chk_rd("kctrl_cleared", KCTRL, 16'h0000);

        // Timer countdown and expiry.
        wr(TIMER, 16'd2);
        chk_rd("timer_load", TIMER, 16'd2);
        tick(3);
        chk_rd("timer_1", TIMER, 16'd1);
        tick(3);
        chk_rd("timer_0", TIMER, 16'd0);
        chk_rd("timer_flag", KCTRL, 16'h0010);
        wr(KCTRL, 16'h0010);
        wr(TIMER, 16'd0);
        tick(6);
        chk_rd("load0_noflag", KCTRL, 16'h0000);
        chk_rd("load0_timer", TIMER, 16'd0);

        // Rewrite on a tick cycle loads without decrement.
        wr(TIMER, 16'd5);
        tick(2);
        wr(TIMER, 16'd4);
        chk_rd("rewrite_load", TIMER, 16'd4);
        tick(3);
        chk_rd("rewrite_dec", TIMER, 16'd3);
        wr(TIMER, 16'd0);
        chk_rd("timer_stop", TIMER, 16'd0);

        // Timer interrupt.
        wr(KCTRL, 16'h1000);
        wr(TIMER, 16'd1);
        tick(3);
        chk_rd("tirq_flag", KCTRL, 16'h1010);
        tick();
        chk("tirq_set", {15'b0, IRQ}, 16'h0001);
        wr(KCTRL, 16'h1010);
        chk_rd("tirq_w1c", KCTRL, 16'h1000);
        tick();
        chk("tirq_clr", {15'b0, IRQ}, 16'h0000);

        // Quiesce and reset the model.
        KEY_IN = 4'hF;
        tick(13);
        wr(KCTRL, 16'h001F);
        wr(KCTRL, 16'h0000);
        m_kdeb  = 4'h0;
        m_kflag = 4'h0;
        m_ken   = 4'h0;
        m_tflag = 1'b0;
        m_ten   = 1'b0;
        chk_rd("quiet_kctrl", KCTRL, m_kctrl());

        // Randomized levels, W1C writes and timer loads.
        for (int it = 0; it < 8; it++) begin
            logic [3:0] km;
            logic [9:0] sw;
            km = 4'($urandom_range(0, 15));
            sw = 10'($urandom_range(0, 1023));
            KEY_IN = ~km;
            SW_IN  = sw;
            m_kflag = m_kflag | (km & ~m_kdeb);
            m_kdeb  = km;
            tick(13);
            chk_rd("rnd_kdata", KDATA, {12'b0, m_kdeb});
            chk_rd("rnd_sdata", SDATA, {6'b0, sw});
            chk_rd("rnd_kctrl", KCTRL, m_kctrl());
            chk("rnd_irq_keys", {15'b0, IRQ}, {15'b0, m_irq()});

            d = 16'($urandom_range(0, 16'h1FFF));
            wr(KCTRL, d);
            m_kflag = m_kflag & ~d[3:0];
            m_tflag = m_tflag & ~d[4];
            m_ken   = d[11:8];
            m_ten   = d[12];
            chk_rd("rnd_kctrl_wr", KCTRL, m_kctrl());
            tick();
            chk("rnd_irq_wr", {15'b0, IRQ}, {15'b0, m_irq()});

            n = int'($urandom_range(0, 4));
            wr(TIMER, 16'(n));
            chk_rd("rnd_tmr_load", TIMER, 16'(n));
            if (n > 0) begin
                tick(3);
                chk_rd("rnd_tmr_step", TIMER, 16'(n - 1));
                tick(3 * (n - 1));
                m_tflag = 1'b1;
            end else begin
                tick(3);
            end
            chk_rd("rnd_tmr_zero", TIMER, 16'd0);
            chk_rd("rnd_tmr_kctrl", KCTRL, m_kctrl());
            tick();
            chk("rnd_irq_tmr", {15'b0, IRQ}, {15'b0, m_irq()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
